writeback_arbiter: RTL and testbench

Collects register write-back requests from the ALU pipeline and the memory/load unit and drives the register file's single write port, one write per cycle. The ALU source is buffered in a small in-order queue. The load source is unbuffered and has priority, but stalls on write-after-write conflicts with queued ALU results. A per-register pending mask is exported so the hazard/stall logic can see outstanding writes.

---
 rtl/writeback_arbiter.sv | 132 +++++++++++++
 tb/tb_writeback_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Register-file write-back arbiter: loads take priority, ALU results go through a small
// in-order queue. A load that would overtake a queued ALU write to the same register is held.
module writeback_arbiter #(
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        rf_write_enable,
    output logic [4:0]  rf_addr_write,
    output logic [31:0] rf_in,
    output logic [31:0] pending_mask
);

    localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CountFull = CntW'(QUEUE_DEPTH);

    logic [4:0]            q_rd_q   [QUEUE_DEPTH];
    logic [31:0]           q_data_q [QUEUE_DEPTH];
    logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  we_q, we_d;
    logic [4:0]            addr_q, addr_d;
    logic [31:0]           data_q, data_d;

    logic [QUEUE_DEPTH-1:0] entry_valid;
    logic [31:0]            queue_mask;
    logic                   waw_hit;
    logic                   alu_acc, mem_acc;
    logic                   push, pop;

    // Entry i is live when its distance from head (mod depth) is below count.
    always_comb begin
        entry_valid = '0;
        queue_mask  = '0;
        waw_hit     = 1'b0;
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            entry_valid[i] = CntW'(PtrW'(PtrW'(i) - head_q)) < count_q;
            if (entry_valid[i]) begin
                queue_mask[q_rd_q[i]] = 1'b1;
                if (q_rd_q[i] == mem_rd) begin
                    waw_hit = 1'b1;
                end
            end
        end
    end

    assign alu_ready = (count_q != CountFull);
    assign mem_ready = !(waw_hit && (mem_rd != 5'd0));
    assign alu_acc   = alu_valid && alu_ready;
    assign mem_acc   = mem_valid && mem_ready;

    always_comb begin
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        pop    = 1'b0;
        push   = 1'b0;
        if (mem_acc && (mem_rd != 5'd0)) begin
            we_d   = 1'b1;
            addr_d = mem_rd;
            data_d = mem_data;
            push   = alu_acc && (alu_rd != 5'd0);
        end else if (count_q != '0) begin
            we_d   = 1'b1;
            addr_d = q_rd_q[head_q];
            data_d = q_data_q[head_q];
            pop    = 1'b1;
            push   = alu_acc && (alu_rd != 5'd0);
        end else if (alu_acc && (alu_rd != 5'd0)) begin
            // Empty queue: bypass straight to the output stage.
            we_d   = 1'b1;
            addr_d = alu_rd;
            data_d = alu_data;
        end
    end

    always_comb begin
        head_d  = pop  ? head_q + PtrW'(1) : head_q;
        tail_d  = push ? tail_q + PtrW'(1) : tail_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                q_rd_q[i]   <= '0;
                q_data_q[i] <= '0;
            end
        end else if (push) begin
            q_rd_q[tail_q]   <= alu_rd;
            q_data_q[tail_q] <= alu_data;
        end
    end

    assign rf_write_enable = we_q;
    assign rf_addr_write   = addr_q;
    assign rf_in           = data_q;
    assign pending_mask    = (queue_mask | (we_q ? (32'd1 << addr_q) : 32'd0)) & ~32'd1;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: hand-computed write sequences, ready flags and
// pending masks across bypass, priority, queue-full, WAW hold, r0 discard and async reset.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        rf_write_enable;
    logic [4:0]  rf_addr_write;
    logic [31:0] rf_in;
    logic [31:0] pending_mask;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    writeback_arbiter #(.QUEUE_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_rd          (mem_rd),
        .mem_data        (mem_data),
        .rf_write_enable (rf_write_enable),
        .rf_addr_write   (rf_addr_write),
        .rf_in           (rf_in),
        .pending_mask    (pending_mask)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
        check({tag, "_we"}, 32'(rf_write_enable), 32'd1);
        check({tag, "_addr"}, 32'(rf_addr_write), 32'(a));
        check({tag, "_data"}, rf_in, d);
    endtask

    task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic set_mem(input logic v, input logic [4:0] rd, input logic [31:0] d);
        mem_valid = v;
        mem_rd    = rd;
        mem_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        set_alu(1'b0, 5'd0, 32'd0);
        set_mem(1'b0, 5'd0, 32'd0);
        #1;
        check("rst_we", 32'(rf_write_enable), 32'd0);
        check("rst_addr", 32'(rf_addr_write), 32'd0);
        check("rst_data", rf_in, 32'd0);
        check("rst_mask", pending_mask, 32'd0);
        check("rst_alu_rdy", 32'(alu_ready), 32'd1);
        check("rst_mem_rdy", 32'(mem_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // ALU bypass: one-cycle latency
        set_alu(1'b1, 5'd5, 32'd42);
        #1;
        check("byp_alu_rdy", 32'(alu_ready), 32'd1);
        tick();
        set_alu(1'b0, 5'd0, 32'd0);
        expect_wr("byp", 5'd5, 32'd42);
        check("byp_mask", pending_mask, 32'h20);
        tick();
        check("byp_idle_we", 32'(rf_write_enable), 32'd0);
        check("byp_idle_mask", pending_mask, 32'd0);

        // Same-cycle load and ALU: load first, ALU next
        set_alu(1'b1, 5'd3, 32'd7);
        set_mem(1'b1, 5'd4, 32'd9);
        tick();
        set_alu(1'b0, 5'd0, 32'd0);
        set_mem(1'b0, 5'd0, 32'd0);
        expect_wr("pri_ld", 5'd4, 32'd9);
        check("pri_mask", pending_mask, 32'h18);
        tick();
        expect_wr("pri_alu", 5'd3, 32'd7);
        check("pri_mask2", pending_mask, 32'h08);
        tick();
        check("pri_idle_we", 32'(rf_write_enable), 32'd0);

        // Fill queue behind a stream of loads
        set_mem(1'b1, 5'd1, 32'd100);
        for (int i = 0; i < 4; i++) begin
            set_alu(1'b1, 5'(10 + i), 32'(32'hA0 + i));
            #1;
            check("fill_alu_rdy", 32'(alu_ready), 32'd1);
            tick();
            expect_wr("fill_ld", 5'd1, 32'd100);
        end
        set_alu(1'b1, 5'd20, 32'hDEAD);
        #1;
        check("full_alu_rdy", 32'(alu_ready), 32'd0);
        check("full_mask", pending_mask, 32'h3C02);
        set_mem(1'b0, 5'd0, 32'd0);
        tick();
        set_alu(1'b0, 5'd0, 32'd0);
        expect_wr("drain0", 5'd10, 32'hA0);
        check("drain_alu_rdy", 32'(alu_ready), 32'd1);
        check("drain_mask", pending_mask, 32'h3C00);
        for (int i = 1; i < 4; i++) begin
            tick();
            expect_wr("drain", 5'(10 + i), 32'(32'hA0 + i));
        end
        tick();
        check("drain_idle_we", 32'(rf_write_enable), 32'd0);
        check("drain_idle_mask", pending_mask, 32'd0);

        // WAW hold: load to r6 waits for queued ALU r6
        set_mem(1'b1, 5'd7, 32'd3);
        set_alu(1'b1, 5'd6, 32'd1);
        tick();
        set_alu(1'b0, 5'd0, 32'd0);
        expect_wr("waw_ld7", 5'd7, 32'd3);
        check("waw_mask", pending_mask, 32'hC0);
        set_mem(1'b1, 5'd6, 32'd2);
        #1;
        check("waw_hold", 32'(mem_ready), 32'd0);
        tick();
        expect_wr("waw_alu6", 5'd6, 32'd1);
        check("waw_release", 32'(mem_ready), 32'd1);
        tick();
        set_mem(1'b0, 5'd0, 32'd0);
        expect_wr("waw_ld6", 5'd6, 32'd2);
        tick();
        check("waw_idle_we", 32'(rf_write_enable), 32'd0);

        // Register 0 writes are accepted and discarded
        set_alu(1'b1, 5'd0, 32'd99);
        set_mem(1'b1, 5'd0, 32'd77);
        #1;
        check("r0_alu_rdy", 32'(alu_ready), 32'd1);
        check("r0_mem_rdy", 32'(mem_ready), 32'd1);
        tick();
        set_alu(1'b0, 5'd0, 32'd0);
        set_mem(1'b0, 5'd0, 32'd0);
        check("r0_we", 32'(rf_write_enable), 32'd0);
        check("r0_mask", pending_mask, 32'd0);
        tick();
        check("r0_we2", 32'(rf_write_enable), 32'd0);

        // Async reset mid-operation discards queue and presented write
        set_mem(1'b1, 5'd2, 32'd55);
        for (int i = 0; i < 3; i++) begin
            set_alu(1'b1, 5'(14 + i), 32'(i));
            tick();
        end
        set_alu(1'b0, 5'd0, 32'd0);
        check("pre_rst_mask", pending_mask, 32'h1C004);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_we", 32'(rf_write_enable), 32'd0);
        check("mid_rst_addr", 32'(rf_addr_write), 32'd0);
        check("mid_rst_data", rf_in, 32'd0);
        check("mid_rst_mask", pending_mask, 32'd0);
        check("mid_rst_alu_rdy", 32'(alu_ready), 32'd1);
        set_mem(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_we", 32'(rf_write_enable), 32'd0);
        end
        check("post_rst_alu_rdy", 32'(alu_ready), 32'd1);
        check("post_rst_mask", pending_mask, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
